// File: rtl/cache_tag_store_pkg.sv
// Shared encodings and helpers for the cache tag store and its victim selector.
// The I-cache reuses the victim selector, so these definitions live in one package.
package cache_tag_store_pkg;

    typedef enum logic [1:0] {
        UP_TOUCH = 2'b00,
        UP_FILL  = 2'b01,
        UP_DIRTY = 2'b10,
        UP_INV   = 2'b11
    } up_op_e;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_READY = 1'b1
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Combinational hit / NRU victim selection across the ways of one set.
// On a miss the victim is the lowest invalid way, else the lowest unreferenced way, else way 0.
module cache_victim_sel #(
    parameter int WAYS  = 2,
    parameter int WAY_W = 1
) (
    input  logic [WAYS-1:0]  valid_vec,
    input  logic [WAYS-1:0]  ref_vec,
    input  logic [WAYS-1:0]  hit_vec,
    output logic             hit,
    output logic [WAY_W-1:0] hit_way,
    output logic [WAY_W-1:0] victim_way
);

    logic             inv_any;
    logic             nref_any;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] nref_way;

    // Scan from the top down so the lowest matching way is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        inv_any  = 1'b0;
        inv_way  = '0;
        nref_any = 1'b0;
        nref_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_vec[w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
            if (!ref_vec[w]) begin
                nref_any = 1'b1;
                nref_way = WAY_W'(w);
            end
        end
        victim_way = inv_any ? inv_way : (nref_any ? nref_way : '0);
    end

endmodule

// File: rtl/cache_tag_store.sv
// Multi-way tag/flag store: registered lookup with NRU victim choice, explicit
// update operations, and a one-set-per-cycle invalidate-all sweep after reset or on request.
module cache_tag_store
    import cache_tag_store_pkg::*;
#(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 14,
    parameter int WAYS    = 2,
    localparam int WAY_W  = (WAYS > 1) ? clog2(WAYS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lk_valid,
    input  logic [INDEX_W-1:0] lk_index,
    input  logic [TAG_W-1:0]   lk_tag,
    output logic               lk_ready,
    output logic               rsp_valid,
    output logic               rsp_hit,
    output logic [WAY_W-1:0]   rsp_way,
    output logic               rsp_dirty,
    output logic [TAG_W-1:0]   rsp_victim_tag,
    input  logic               up_valid,
    input  logic [INDEX_W-1:0] up_index,
    input  logic [WAY_W-1:0]   up_way,
    input  logic [1:0]         up_op,
    input  logic [TAG_W-1:0]   up_tag,
    input  logic               up_dirty,
    input  logic               inv_all,
    output logic               busy
);

    localparam int SETS = 1 << INDEX_W;

    state_e             state_reg, state_next;
    logic [INDEX_W-1:0] sweep_cnt_reg, sweep_cnt_next;

    logic [WAYS-1:0]  valid_reg [SETS];
    logic [WAYS-1:0]  dirty_reg [SETS];
    logic [WAYS-1:0]  ref_reg   [SETS];
    logic [TAG_W-1:0] tag_reg   [SETS][WAYS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_SWEEP;
            sweep_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sweep_cnt_reg <= sweep_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sweep_cnt_next = sweep_cnt_reg;
        case (state_reg)
            ST_SWEEP: begin
                sweep_cnt_next = sweep_cnt_reg + 1'b1;
                if (sweep_cnt_reg == INDEX_W'(SETS - 1)) state_next = ST_READY;
            end
            ST_READY: begin
                if (inv_all) begin
                    state_next     = ST_SWEEP;
                    sweep_cnt_next = '0;
                end
            end
        endcase
    end

    assign busy     = (state_reg == ST_SWEEP);
    assign lk_ready = !busy;

    // Lookup path: tag compare on the addressed set, result registered.
    logic [WAYS-1:0]  lk_valid_vec, lk_ref_vec, lk_hit_vec;
    logic             sel_hit;
    logic [WAY_W-1:0] sel_hit_way, sel_victim_way, sel_way;
    logic             lk_accept;

    assign lk_valid_vec = valid_reg[lk_index];
    assign lk_ref_vec   = ref_reg[lk_index];
    assign lk_accept    = lk_valid && lk_ready;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_cmp
            assign lk_hit_vec[gi] = lk_valid_vec[gi] && (tag_reg[lk_index][gi] == lk_tag);
        end
    endgenerate

    cache_victim_sel #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_victim_sel (
        .valid_vec  (lk_valid_vec),
        .ref_vec    (lk_ref_vec),
        .hit_vec    (lk_hit_vec),
        .hit        (sel_hit),
        .hit_way    (sel_hit_way),
        .victim_way (sel_victim_way)
    );

    assign sel_way = sel_hit ? sel_hit_way : sel_victim_way;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid      <= 1'b0;
            rsp_hit        <= 1'b0;
            rsp_way        <= '0;
            rsp_dirty      <= 1'b0;
            rsp_victim_tag <= '0;
        end else begin
            rsp_valid <= lk_accept;
            if (lk_accept) begin
                rsp_hit        <= sel_hit;
                rsp_way        <= sel_way;
                rsp_dirty      <= dirty_reg[lk_index][sel_way];
                rsp_victim_tag <= tag_reg[lk_index][sel_way];
            end
        end
    end

    // Update path: compute the new flag vectors of the addressed set.
    logic            up_we, up_touch;
    logic [WAYS-1:0] up_mask, up_valid_new, up_dirty_new, up_ref_new;

    assign up_we = !rst && (state_reg == ST_READY) && up_valid && !inv_all
                   && (int'(up_way) < WAYS);

    always_comb begin
        up_mask      = WAYS'(1) << up_way;
        up_valid_new = valid_reg[up_index];
        up_dirty_new = dirty_reg[up_index];
        up_ref_new   = ref_reg[up_index];
        up_touch     = 1'b0;
        case (up_op_e'(up_op))
            UP_TOUCH: up_touch = 1'b1;
            UP_FILL: begin
                up_valid_new = up_valid_new | up_mask;
                up_dirty_new = up_dirty ? (up_dirty_new | up_mask) : (up_dirty_new & ~up_mask);
                up_touch     = 1'b1;
            end
            UP_DIRTY: up_dirty_new = up_dirty_new | (up_mask & valid_reg[up_index]);
            UP_INV: begin
                up_valid_new = up_valid_new & ~up_mask;
                up_dirty_new = up_dirty_new & ~up_mask;
                up_ref_new   = up_ref_new & ~up_mask;
            end
        endcase
        // NRU epoch: once every valid way is referenced, keep only the touched one.
        if (up_touch) begin
            up_ref_new = up_ref_new | up_mask;
            if ((up_ref_new & up_valid_new) == up_valid_new) up_ref_new = up_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_reg == ST_SWEEP) begin
            valid_reg[sweep_cnt_reg] <= '0;
            dirty_reg[sweep_cnt_reg] <= '0;
            ref_reg[sweep_cnt_reg]   <= '0;
            for (int w = 0; w < WAYS; w++) tag_reg[sweep_cnt_reg][w] <= '0;
        end else if (up_we) begin
            valid_reg[up_index] <= up_valid_new;
            dirty_reg[up_index] <= up_dirty_new;
            ref_reg[up_index]   <= up_ref_new;
            if (up_op_e'(up_op) == UP_FILL) tag_reg[up_index][up_way] <= up_tag;
        end
    end

endmodule
